// File: rtl/store_buffer.sv
// Posted-write buffer: queues single-cycle core stores and drains them in order to a handshaked memory.
// Forwards the youngest queued store to loads of the same word so program order is preserved.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  output logic                   stall,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_adr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    adr_q [DEPTH];
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt_q;

  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;

  assign count   = cnt_q;
  assign mem_req = (cnt_q != '0);
  assign stall   = (cnt_q == CW'(DEPTH)) & memwrite;
  assign push    = memwrite & ~stall;
  assign pop     = mem_req & mem_ack;

  // Head entry is only presented while a request is outstanding; idle bus reads as zero.
  assign mem_adr   = mem_req ? adr_q[head] : '0;
  assign mem_wdata = mem_req ? dat_q[head] : '0;

  // Walk oldest to youngest so the last match, nearest the tail, wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld_q[idx] && (adr_q[idx][AW-1:2] == dataadr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = dat_q[idx];
      end
    end
    if (memwrite) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      // Push and pop never collide on one slot: push is blocked when full, pop needs a non-empty queue.
      if (push) begin
        adr_q[tail] <= dataadr;
        dat_q[tail] <= writedata;
        vld_q[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: vector table for the main flows, hand sequences for reset and push/pop overlap,
// and an in-order drain scoreboard fed from captured stores.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        stall;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb [$];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .stall(stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic        stl;
    logic        hit;
    logic [31:0] fwd;
    logic [2:0]  cnt;
    logic        req;
    logic [31:0] madr;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat, logic ack,
                              logic stl, logic hit, logic [31:0] fwd,
                              logic [2:0] cnt, logic req, logic [31:0] madr);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.ack = ack; v.stl = stl;
    v.hit = hit; v.fwd = fwd; v.cnt = cnt; v.req = req; v.madr = madr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic ack);
    memwrite  = we;
    dataadr   = adr;
    writedata = dat;
    mem_ack   = ack;
    #1;
  endtask

  // Called with inputs settled mid-cycle; models what the coming edge commits.
  task automatic edge_step();
    logic [63:0] e;
    if (reset) begin
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL drain_unexpected: got adr 0x%0h data 0x%0h expected no write", mem_adr, mem_wdata);
        end else begin
          e = sb.pop_front();
          check("drain_adr", {32'h0, mem_adr}, {32'h0, e[63:32]});
          check("drain_data", {32'h0, mem_wdata}, {32'h0, e[31:0]});
        end
      end
      if (memwrite && !stall) sb.push_back({dataadr, writedata});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hit", 64'(fwd_hit), 64'd0);
    check("rst_fwd", 64'(fwd_data), 64'd0);
    check("rst_madr", 64'(mem_adr), 64'd0);
    check("rst_mwdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ordered drain, full/stall with wrap, then forwarding.
    vecs[0]  = mk(1, 80, 5, 0,       0, 0, 0,     1, 1, 80);
    vecs[1]  = mk(1, 84, 7, 0,       0, 0, 0,     2, 1, 80);
    vecs[2]  = mk(0, 0, 0, 0,        0, 0, 0,     2, 1, 80);
    vecs[3]  = mk(0, 0, 0, 1,        0, 0, 0,     1, 1, 84);
    vecs[4]  = mk(0, 0, 0, 1,        0, 0, 0,     0, 0, 0);
    vecs[5]  = mk(1, 0, 32'hA0, 0,   0, 0, 0,     1, 1, 0);
    vecs[6]  = mk(1, 4, 32'hA1, 0,   0, 0, 0,     2, 1, 0);
    vecs[7]  = mk(1, 8, 32'hA2, 0,   0, 0, 0,     3, 1, 0);
    vecs[8]  = mk(1, 12, 32'hA3, 0,  0, 0, 0,     4, 1, 0);
    vecs[9]  = mk(1, 16, 9, 0,       1, 0, 0,     4, 1, 0);
    vecs[10] = mk(1, 16, 9, 1,       1, 0, 0,     3, 1, 4);
    vecs[11] = mk(1, 16, 9, 0,       0, 0, 0,     4, 1, 4);
    vecs[12] = mk(0, 0, 0, 1,        0, 0, 0,     3, 1, 8);
    vecs[13] = mk(0, 0, 0, 1,        0, 0, 0,     2, 1, 12);
    vecs[14] = mk(0, 0, 0, 1,        0, 0, 0,     1, 1, 16);
    vecs[15] = mk(0, 0, 0, 1,        0, 0, 0,     0, 0, 0);
    vecs[16] = mk(1, 84, 7, 0,       0, 0, 0,     1, 1, 84);
    vecs[17] = mk(1, 84, 3, 0,       0, 0, 0,     2, 1, 84);
    vecs[18] = mk(0, 84, 0, 0,       0, 1, 3,     2, 1, 84);
    vecs[19] = mk(0, 86, 0, 0,       0, 1, 3,     2, 1, 84);
    vecs[20] = mk(0, 88, 0, 0,       0, 0, 0,     2, 1, 84);
    vecs[21] = mk(1, 84, 32'h55, 0,  0, 0, 0,     3, 1, 84);
    vecs[22] = mk(0, 84, 0, 1,       0, 1, 32'h55, 2, 1, 84);
    vecs[23] = mk(0, 80, 0, 1,       0, 0, 0,     1, 1, 84);
    vecs[24] = mk(0, 84, 0, 1,       0, 1, 32'h55, 0, 0, 0);
    vecs[25] = mk(0, 84, 0, 0,       0, 0, 0,     0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].ack);
      check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].stl));
      check($sformatf("v%0d_hit", i), 64'(fwd_hit), 64'(vecs[i].hit));
      check($sformatf("v%0d_fwd", i), 64'(fwd_data), 64'(vecs[i].fwd));
      edge_step();
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      check($sformatf("v%0d_req", i), 64'(mem_req), 64'(vecs[i].req));
      if (vecs[i].req) check($sformatf("v%0d_madr", i), 64'(mem_adr), 64'(vecs[i].madr));
    end

    // Push and pop in the same cycle at count 1.
    drive(1, 200, 32'h11, 0);
    edge_step();
    check("pp_count0", 64'(count), 64'd1);
    drive(1, 204, 32'h22, 1);
    edge_step();
    check("pp_count1", 64'(count), 64'd1);
    check("pp_madr", 64'(mem_adr), 64'd204);
    check("pp_wdata", 64'(mem_wdata), 64'h22);
    drive(0, 0, 0, 1);
    edge_step();
    check("pp_count2", 64'(count), 64'd0);

    // Ack while empty is ignored.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      edge_step();
      check($sformatf("idle_ack%0d_count", i), 64'(count), 64'd0);
      check($sformatf("idle_ack%0d_req", i), 64'(mem_req), 64'd0);
    end
    drive(1, 300, 32'h33, 0);
    edge_step();
    check("idle_madr", 64'(mem_adr), 64'd300);
    check("idle_wdata", 64'(mem_wdata), 64'h33);
    drive(0, 0, 0, 1);
    edge_step();
    check("idle_drain_count", 64'(count), 64'd0);

    // Asynchronous reset mid-drain abandons queued stores.
    drive(1, 400, 32'h44, 0);
    edge_step();
    drive(1, 404, 32'h45, 0);
    edge_step();
    check("mid_count", 64'(count), 64'd2);
    check("mid_req", 64'(mem_req), 64'd1);
    drive(0, 400, 0, 0);
    reset = 1'b0;
    #1;
    check("arst_req", 64'(mem_req), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_hit", 64'(fwd_hit), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 400, 0, 1);
      check($sformatf("post_rst%0d_hit", i), 64'(fwd_hit), 64'd0);
      edge_step();
      check($sformatf("post_rst%0d_count", i), 64'(count), 64'd0);
      check($sformatf("post_rst%0d_req", i), 64'(mem_req), 64'd0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
